riviera_mem_arbiter: RTL and testbench

Single-port memory arbiter that shares one unified memory interface between the IF stage instruction fetch and the MEM stage load/store unit. Grants one transaction at a time, with data-side priority and a bounded anti-starvation rule for fetch. Drops fetch responses invalidated by an EX-stage flush. Sits between the core stages and the memory model/controller, one level below the core top.

---
 rtl/riviera_mem_arbiter_if.sv | 49 ++++
 rtl/riviera_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_riviera_mem_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riviera_mem_arbiter_if.sv
// Bundle of fetch, load/store and unified-memory signals for riviera_mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the core/memory side.
interface riviera_mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  i_if_req;
  logic [ADDR_W-1:0]     i_if_addr;
  logic                  i_if_flush;
  logic                  o_if_gnt;
  logic                  o_if_rvalid;
  logic [31:0]           o_if_rdata;

  logic                  i_dm_req;
  logic                  i_dm_we;
  logic [ADDR_W-1:0]     i_dm_addr;
  logic [DATA_W-1:0]     i_dm_wdata;
  logic [DATA_W/8-1:0]   i_dm_be;
  logic                  o_dm_gnt;
  logic                  o_dm_rvalid;
  logic [DATA_W-1:0]     o_dm_rdata;

  logic                  o_mem_req;
  logic                  o_mem_we;
  logic [ADDR_W-1:0]     o_mem_addr;
  logic [DATA_W-1:0]     o_mem_wdata;
  logic [DATA_W/8-1:0]   o_mem_be;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [DATA_W-1:0]     i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr, i_if_flush,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr, i_if_flush,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata, i_dm_be,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/riviera_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and the load/store unit; data has priority, fetch is protected from starvation.
module riviera_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  riviera_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner_if;
  logic             addr2;
  logic             drop;
  logic [CNT_W-1:0] starve_cnt;

  logic if_eff;
  logic pick_if;
  logic sel_if;
  logic req_on;
  logic rsp_on;
  logic gnt_if;
  logic gnt_dm;

  // Winner selection and request/response qualification for the current state
  always_comb begin
    if_eff  = bus.i_if_req & ~bus.i_if_flush;
    pick_if = if_eff & (~bus.i_dm_req | (starve_cnt == LIMIT));
    sel_if  = 1'b0;
    req_on  = 1'b0;
    rsp_on  = 1'b0;
    case (state)
      IDLE: begin
        sel_if = pick_if;
        req_on = pick_if | bus.i_dm_req;
      end
      REQ: begin
        sel_if = owner_if;
        req_on = 1'b1;
      end
      RESP: begin
        sel_if = owner_if;
        rsp_on = bus.i_mem_rvalid;
      end
      default: begin
        sel_if = 1'b0;
        req_on = 1'b0;
        rsp_on = 1'b0;
      end
    endcase
    gnt_if = req_on & bus.i_mem_gnt & sel_if;
    gnt_dm = req_on & bus.i_mem_gnt & ~sel_if;
  end

  // Output drive; everything is forced low while rst_n is asserted
  always_comb begin
    bus.o_mem_req   = rst_n & req_on;
    bus.o_mem_we    = rst_n & req_on & ~sel_if & bus.i_dm_we;
    bus.o_mem_addr  = {ADDR_W{1'b0}};
    bus.o_mem_wdata = {DATA_W{1'b0}};
    bus.o_mem_be    = {BE_W{1'b0}};
    if (rst_n && req_on) begin
      if (sel_if) begin
        bus.o_mem_addr  = bus.i_if_addr;
        bus.o_mem_wdata = {DATA_W{1'b0}};
        bus.o_mem_be    = {BE_W{1'b1}};
      end else begin
        bus.o_mem_addr  = bus.i_dm_addr;
        bus.o_mem_wdata = bus.i_dm_wdata;
        bus.o_mem_be    = bus.i_dm_be;
      end
    end else begin
      bus.o_mem_addr  = {ADDR_W{1'b0}};
      bus.o_mem_wdata = {DATA_W{1'b0}};
      bus.o_mem_be    = {BE_W{1'b0}};
    end

    bus.o_if_gnt    = rst_n & gnt_if;
    bus.o_dm_gnt    = rst_n & gnt_dm;
    // A flush in the response cycle itself also kills the instruction
    bus.o_if_rvalid = rst_n & rsp_on & owner_if & ~drop & ~bus.i_if_flush;
    bus.o_dm_rvalid = rst_n & rsp_on & ~owner_if;

    if (rst_n) begin
      bus.o_if_rdata = addr2 ? bus.i_mem_rdata[63:32] : bus.i_mem_rdata[31:0];
      bus.o_dm_rdata = bus.i_mem_rdata;
    end else begin
      bus.o_if_rdata = 32'd0;
      bus.o_dm_rdata = {DATA_W{1'b0}};
    end
  end

  // Transaction FSM with owner lock, fetch-drop flag and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner_if   <= 1'b0;
      addr2      <= 1'b0;
      drop       <= 1'b0;
      starve_cnt <= {CNT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (req_on) begin
            owner_if <= pick_if;
            drop     <= 1'b0;
            state    <= bus.i_mem_gnt ? RESP : REQ;
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (owner_if && bus.i_if_flush) begin
            drop <= 1'b1;
          end else begin
            drop <= drop;
          end
          state <= bus.i_mem_gnt ? RESP : REQ;
        end
        RESP: begin
          if (bus.i_mem_rvalid) begin
            drop  <= 1'b0;
            state <= IDLE;
          end else if (owner_if && bus.i_if_flush) begin
            drop  <= 1'b1;
            state <= RESP;
          end else begin
            state <= RESP;
          end
        end
        default: begin
          state <= IDLE;
          drop  <= 1'b0;
        end
      endcase

      if (gnt_if) begin
        addr2 <= bus.i_if_addr[2];
      end else begin
        addr2 <= addr2;
      end

      // Count data grants that made a waiting fetch step aside
      if (gnt_if) begin
        starve_cnt <= {CNT_W{1'b0}};
      end else if (gnt_dm) begin
        if (!bus.i_if_req) begin
          starve_cnt <= {CNT_W{1'b0}};
        end else if (starve_cnt != LIMIT) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
          starve_cnt <= starve_cnt;
        end
      end else begin
        starve_cnt <= starve_cnt;
      end
    end
  end
endmodule

// File: tb/tb_riviera_mem_arbiter.sv
// Directed bench for riviera_mem_arbiter: inputs change 1 ns after the rising
// edge, combinational outputs are sampled on the falling edge.
module tb_riviera_mem_arbiter;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  riviera_mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  riviera_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.i_if_req     = 1'b0;
    bus.i_if_addr    = 64'd0;
    bus.i_if_flush   = 1'b0;
    bus.i_dm_req     = 1'b0;
    bus.i_dm_we      = 1'b0;
    bus.i_dm_addr    = 64'd0;
    bus.i_dm_wdata   = 64'd0;
    bus.i_dm_be      = 8'd0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = 64'd0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    clear_inputs();
    rst_n = 1'b0;
    // Outputs stay low in reset even with everything asserted
    bus.i_if_req     = 1'b1;
    bus.i_dm_req     = 1'b1;
    bus.i_dm_addr    = 64'h10;
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    mid();
    check("rst_mem_req", bus.o_mem_req, 64'd0);
    check("rst_dm_gnt", bus.o_dm_gnt, 64'd0);
    check("rst_if_gnt", bus.o_if_gnt, 64'd0);
    check("rst_dm_rvalid", bus.o_dm_rvalid, 64'd0);
    check("rst_mem_addr", bus.o_mem_addr, 64'd0);
    tick();
    clear_inputs();
    rst_n = 1'b1;
    mid();
    check("post_rst_mem_req", bus.o_mem_req, 64'd0);
    check("post_rst_if_rvalid", bus.o_if_rvalid, 64'd0);

    // Lone fetch, granted same cycle, upper half returned
    tick();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h1004;
    bus.i_mem_gnt = 1'b1;
    mid();
    check("f1_mem_req", bus.o_mem_req, 64'd1);
    check("f1_mem_addr", bus.o_mem_addr, 64'h1004);
    check("f1_mem_we", bus.o_mem_we, 64'd0);
    check("f1_if_gnt", bus.o_if_gnt, 64'd1);
    check("f1_dm_gnt", bus.o_dm_gnt, 64'd0);
    tick();
    bus.i_if_req     = 1'b0;
    bus.i_mem_gnt    = 1'b1;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hAAAA_BBBB_1111_2222;
    mid();
    check("f1_if_rvalid", bus.o_if_rvalid, 64'd1);
    check("f1_if_rdata", bus.o_if_rdata, 64'hAAAABBBB);
    check("f1_dm_rvalid", bus.o_dm_rvalid, 64'd0);
    check("f1_resp_mem_req", bus.o_mem_req, 64'd0);
    check("f1_resp_if_gnt", bus.o_if_gnt, 64'd0);

    // Stray rvalid in IDLE is ignored
    tick();
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    mid();
    check("idle_rv_if", bus.o_if_rvalid, 64'd0);
    check("idle_rv_dm", bus.o_dm_rvalid, 64'd0);

    // Fetch and load together: load first, then fetch
    tick();
    clear_inputs();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h2000;
    bus.i_dm_req  = 1'b1;
    bus.i_dm_addr = 64'h3008;
    bus.i_dm_be   = 8'hFF;
    bus.i_mem_gnt = 1'b1;
    mid();
    check("pri_dm_gnt", bus.o_dm_gnt, 64'd1);
    check("pri_if_gnt", bus.o_if_gnt, 64'd0);
    check("pri_mem_addr", bus.o_mem_addr, 64'h3008);
    check("pri_mem_be", bus.o_mem_be, 64'hFF);
    tick();
    bus.i_dm_req     = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'h0123_4567_89AB_CDEF;
    mid();
    check("pri_dm_rvalid", bus.o_dm_rvalid, 64'd1);
    check("pri_dm_rdata", bus.o_dm_rdata, 64'h0123_4567_89AB_CDEF);
    check("pri_if_rvalid", bus.o_if_rvalid, 64'd0);
    check("pri_resp_if_gnt", bus.o_if_gnt, 64'd0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    mid();
    check("pri_f_gnt", bus.o_if_gnt, 64'd1);
    check("pri_f_addr", bus.o_mem_addr, 64'h2000);
    tick();
    bus.i_if_req     = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hAAAA_BBBB_1111_2222;
    mid();
    check("pri_f_rdata_lo", bus.o_if_rdata, 64'h11112222);
    check("pri_f_rvalid", bus.o_if_rvalid, 64'd1);

    // Continuous contention: D,D,D,D,F,D,D,D,D,F
    tick();
    clear_inputs();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h2000;
    bus.i_dm_req  = 1'b1;
    bus.i_dm_addr = 64'h3000;
    bus.i_dm_be   = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      bus.i_mem_gnt    = 1'b1;
      bus.i_mem_rvalid = 1'b0;
      mid();
      check($sformatf("stv_if_gnt_%0d", i), bus.o_if_gnt, ((i == 4) || (i == 9)) ? 64'd1 : 64'd0);
      check($sformatf("stv_dm_gnt_%0d", i), bus.o_dm_gnt, ((i == 4) || (i == 9)) ? 64'd0 : 64'd1);
      tick();
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      mid();
      check($sformatf("stv_if_rv_%0d", i), bus.o_if_rvalid, ((i == 4) || (i == 9)) ? 64'd1 : 64'd0);
      check($sformatf("stv_dm_rv_%0d", i), bus.o_dm_rvalid, ((i == 4) || (i == 9)) ? 64'd0 : 64'd1);
      tick();
    end

    // Memory stalls 3 cycles; owner stays fetch despite a data request
    clear_inputs();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h4000;
    mid();
    check("stall_req0", bus.o_mem_req, 64'd1);
    check("stall_gnt0", bus.o_if_gnt, 64'd0);
    tick();
    bus.i_dm_req  = 1'b1;
    bus.i_dm_addr = 64'h5000;
    bus.i_dm_be   = 8'hFF;
    mid();
    check("stall_addr1", bus.o_mem_addr, 64'h4000);
    check("stall_dm_gnt1", bus.o_dm_gnt, 64'd0);
    tick();
    mid();
    check("stall_addr2", bus.o_mem_addr, 64'h4000);
    check("stall_req2", bus.o_mem_req, 64'd1);
    tick();
    bus.i_mem_gnt = 1'b1;
    mid();
    check("stall_if_gnt", bus.o_if_gnt, 64'd1);
    check("stall_dm_gnt3", bus.o_dm_gnt, 64'd0);
    check("stall_addr3", bus.o_mem_addr, 64'h4000);
    tick();
    bus.i_if_req     = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    mid();
    check("stall_if_rv", bus.o_if_rvalid, 64'd1);
    tick();
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_gnt    = 1'b1;
    mid();
    check("stall_dm_gnt", bus.o_dm_gnt, 64'd1);
    check("stall_dm_addr", bus.o_mem_addr, 64'h5000);
    tick();
    bus.i_dm_req     = 1'b0;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    mid();
    check("stall_dm_rv", bus.o_dm_rvalid, 64'd1);

    // Flush during RESP drops the response; next fetch is normal
    tick();
    clear_inputs();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h6004;
    bus.i_mem_gnt = 1'b1;
    mid();
    check("fl_if_gnt", bus.o_if_gnt, 64'd1);
    tick();
    clear_inputs();
    bus.i_if_flush = 1'b1;
    mid();
    check("fl_rv0", bus.o_if_rvalid, 64'd0);
    tick();
    bus.i_if_flush = 1'b0;
    mid();
    check("fl_rv1", bus.o_if_rvalid, 64'd0);
    tick();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'h5555_6666_7777_8888;
    mid();
    check("fl_rv2", bus.o_if_rvalid, 64'd0);
    check("fl_dm_rv2", bus.o_dm_rvalid, 64'd0);
    tick();
    clear_inputs();
    bus.i_if_req  = 1'b1;
    bus.i_if_addr = 64'h7004;
    bus.i_mem_gnt = 1'b1;
    mid();
    check("fl_next_gnt", bus.o_if_gnt, 64'd1);
    tick();
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hDEAD_BEEF_CAFE_F00D;
    mid();
    check("fl_next_rv", bus.o_if_rvalid, 64'd1);
    check("fl_next_rdata", bus.o_if_rdata, 64'hDEADBEEF);

    // Store granted, then asynchronous reset while in RESP
    tick();
    clear_inputs();
    bus.i_dm_req   = 1'b1;
    bus.i_dm_we    = 1'b1;
    bus.i_dm_addr  = 64'h8000;
    bus.i_dm_wdata = 64'h1122_3344_5566_7788;
    bus.i_dm_be    = 8'h0F;
    bus.i_mem_gnt  = 1'b1;
    mid();
    check("st_dm_gnt", bus.o_dm_gnt, 64'd1);
    check("st_mem_we", bus.o_mem_we, 64'd1);
    check("st_wdata", bus.o_mem_wdata, 64'h1122_3344_5566_7788);
    check("st_be", bus.o_mem_be, 64'h0F);
    tick();
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    #1;
    check("st_ack_pre_rst", bus.o_dm_rvalid, 64'd1);
    rst_n = 1'b0;
    #1;
    check("st_rst_dm_rv", bus.o_dm_rvalid, 64'd0);
    check("st_rst_mem_req", bus.o_mem_req, 64'd0);
    bus.i_mem_rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.i_dm_req  = 1'b1;
    bus.i_dm_addr = 64'h9000;
    bus.i_dm_be   = 8'hFF;
    bus.i_mem_gnt = 1'b1;
    mid();
    check("ld_dm_gnt", bus.o_dm_gnt, 64'd1);
    check("ld_mem_we", bus.o_mem_we, 64'd0);
    check("ld_mem_addr", bus.o_mem_addr, 64'h9000);
    tick();
    clear_inputs();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata  = 64'hFEED_FACE_0123_4567;
    mid();
    check("ld_dm_rv", bus.o_dm_rvalid, 64'd1);
    check("ld_dm_rdata", bus.o_dm_rdata, 64'hFEED_FACE_0123_4567);
    tick();
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
